// File: rtl/codec_link_pkg.sv
// Shared definitions for the codec_link serial DSP-port link.
package codec_link_pkg;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_DIV_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      SHIFT = 2'd2
   } tx_state_e;

   typedef enum logic [0:0] {
      RX_IDLE = 1'b0,
      RX_BUSY = 1'b1
   } rx_state_e;

endpackage

// File: rtl/codec_link_sclk_gen.sv
// Bit-clock divider: toggles sclk every (div+1) clk cycles and flags each edge
// with a one-cycle tick aligned to the clk edge that moves sclk.
module sclk_gen
   import codec_link_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             rise_tick,
   output logic             fall_tick
);

   logic [DIV_W-1:0] cnt_r;
   logic [DIV_W-1:0] lim_r;
   logic             sclk_r;
   logic             tc_s;

   assign tc_s      = en & (cnt_r == lim_r);
   assign rise_tick = tc_s & ~sclk_r;
   assign fall_tick = tc_s & sclk_r;
   assign sclk      = sclk_r;

   // Half-period counter; the limit is re-sampled only at terminal count (or while idle).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r  <= '0;
         lim_r  <= '0;
         sclk_r <= 1'b0;
      end else if (!en) begin
         cnt_r  <= '0;
         lim_r  <= div;
         sclk_r <= 1'b0;
      end else if (tc_s) begin
         cnt_r  <= '0;
         lim_r  <= div;
         sclk_r <= ~sclk_r;
      end else begin
         cnt_r  <= cnt_r + DIV_W'(1'b1);
      end
   end

endmodule

// File: rtl/codec_link.sv
// Serial codec link: framed TX shifted on sclk rise from a one-word holding
// register, framed RX sampled on sclk fall.
module codec_link
   import codec_link_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int DIV_W  = DEF_DIV_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  div,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              sclk,
   output logic              sdofs,
   output logic              sdo,
   input  logic              sdifs,
   input  logic              sdi
);

   localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1'b1);

   logic              rise_tick_s;
   logic              fall_tick_s;

   tx_state_e         tx_state_r, tx_state_s;
   logic [WORD_W-1:0] shreg_r, shreg_s;
   logic [WORD_W-1:0] hold_r, hold_s;
   logic [CNT_W-1:0]  bitcnt_r, bitcnt_s;
   logic              sdofs_r, sdofs_s;
   logic              sdo_r, sdo_s;
   logic              full_r, full_s;
   logic              ready_r;
   logic              load_s;
   logic              accept_s;

   rx_state_e         rx_state_r, rx_state_s;
   logic [WORD_W-1:0] rx_sh_r, rx_sh_s;
   logic [WORD_W-1:0] rx_data_r, rx_data_s;
   logic [CNT_W-1:0]  rx_cnt_r, rx_cnt_s;
   logic              rx_pend_r, rx_pend_s;
   logic              rx_valid_r, rx_valid_s;

   sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div       (div),
      .sclk      (sclk),
      .rise_tick (rise_tick_s),
      .fall_tick (fall_tick_s)
   );

   assign accept_s = tx_valid & ~full_r;
   assign tx_ready = ready_r;
   assign sdofs    = sdofs_r;
   assign sdo      = sdo_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;

   // TX frame sequencer: every output move is tied to a rising sclk edge.
   always_comb begin
      tx_state_s = tx_state_r;
      shreg_s    = shreg_r;
      bitcnt_s   = bitcnt_r;
      sdofs_s    = sdofs_r;
      sdo_s      = sdo_r;
      load_s     = 1'b0;
      if (!en) begin
         tx_state_s = IDLE;
         sdofs_s    = 1'b0;
         sdo_s      = 1'b0;
         bitcnt_s   = '0;
      end else if (rise_tick_s) begin
         case (tx_state_r)
            IDLE: begin
               sdo_s = 1'b0;
               if (full_r) begin
                  load_s     = 1'b1;
                  shreg_s    = hold_r;
                  sdofs_s    = 1'b1;
                  tx_state_s = SYNC;
               end else begin
                  sdofs_s    = 1'b0;
               end
            end
            SYNC: begin
               sdofs_s    = 1'b0;
               sdo_s      = shreg_r[WORD_W-1];
               shreg_s    = {shreg_r[WORD_W-2:0], 1'b0};
               bitcnt_s   = LAST_BIT;
               tx_state_s = SHIFT;
            end
            SHIFT: begin
               if (bitcnt_r != '0) begin
                  sdo_s    = shreg_r[WORD_W-1];
                  shreg_s  = {shreg_r[WORD_W-2:0], 1'b0};
                  bitcnt_s = bitcnt_r - ONE_C;
               end else if (full_r) begin
                  // LSB period over and another word waiting: chain the next frame.
                  load_s     = 1'b1;
                  shreg_s    = hold_r;
                  sdofs_s    = 1'b1;
                  sdo_s      = 1'b0;
                  tx_state_s = SYNC;
               end else begin
                  sdo_s      = 1'b0;
                  tx_state_s = IDLE;
               end
            end
            default: begin
               tx_state_s = IDLE;
               sdofs_s    = 1'b0;
               sdo_s      = 1'b0;
            end
         endcase
      end else begin
         load_s = 1'b0;
      end
   end

   // Holding register handshake; contents survive en=0.
   always_comb begin
      hold_s = hold_r;
      full_s = full_r;
      if (accept_s) begin
         hold_s = tx_data;
         full_s = 1'b1;
      end else if (load_s) begin
         full_s = 1'b0;
      end else begin
         full_s = full_r;
      end
   end

   // TX and holding-register state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_r <= IDLE;
         shreg_r    <= '0;
         hold_r     <= '0;
         bitcnt_r   <= '0;
         sdofs_r    <= 1'b0;
         sdo_r      <= 1'b0;
         full_r     <= 1'b0;
         ready_r    <= 1'b1;
      end else begin
         tx_state_r <= tx_state_s;
         shreg_r    <= shreg_s;
         hold_r     <= hold_s;
         bitcnt_r   <= bitcnt_s;
         sdofs_r    <= sdofs_s;
         sdo_r      <= sdo_s;
         full_r     <= full_s;
         ready_r    <= ~full_s;
      end
   end

   // RX deframer: sdifs on a falling sclk edge (re)arms, then WORD_W bits shift in.
   always_comb begin
      rx_state_s = rx_state_r;
      rx_sh_s    = rx_sh_r;
      rx_cnt_s   = rx_cnt_r;
      rx_pend_s  = 1'b0;
      rx_data_s  = rx_data_r;
      rx_valid_s = 1'b0;
      if (rx_pend_r) begin
         rx_data_s  = rx_sh_r;
         rx_valid_s = 1'b1;
      end else begin
         rx_data_s  = rx_data_r;
      end
      if (!en) begin
         rx_state_s = RX_IDLE;
         rx_cnt_s   = '0;
      end else if (fall_tick_s) begin
         if (sdifs) begin
            rx_state_s = RX_BUSY;
            rx_cnt_s   = '0;
         end else begin
            case (rx_state_r)
               RX_BUSY: begin
                  rx_sh_s = {rx_sh_r[WORD_W-2:0], sdi};
                  if (rx_cnt_r == LAST_BIT) begin
                     rx_state_s = RX_IDLE;
                     rx_cnt_s   = '0;
                     rx_pend_s  = 1'b1;
                  end else begin
                     rx_cnt_s   = rx_cnt_r + ONE_C;
                  end
               end
               RX_IDLE: begin
                  rx_state_s = RX_IDLE;
               end
               default: begin
                  rx_state_s = RX_IDLE;
                  rx_cnt_s   = '0;
               end
            endcase
         end
      end else begin
         rx_state_s = rx_state_r;
      end
   end

   // RX state and the registered word/strobe outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_r <= RX_IDLE;
         rx_sh_r    <= '0;
         rx_cnt_r   <= '0;
         rx_pend_r  <= 1'b0;
         rx_data_r  <= '0;
         rx_valid_r <= 1'b0;
      end else begin
         rx_state_r <= rx_state_s;
         rx_sh_r    <= rx_sh_s;
         rx_cnt_r   <= rx_cnt_s;
         rx_pend_r  <= rx_pend_s;
         rx_data_r  <= rx_data_s;
         rx_valid_r <= rx_valid_s;
      end
   end

endmodule
